// File: rtl/wb_timer_if.sv
// Wishbone classic 16-bit bus bundle shared by the wb_timer responder and its bus master.
interface wb_timer_if #(
  parameter int ADDR_WIDTH = 24
);
  logic [ADDR_WIDTH-1:0] wb_adr_i;
  logic [15:0]           wb_dat_i;
  logic [15:0]           wb_dat_o;
  logic [1:0]            wb_sel_i;
  logic                  wb_we_i;
  logic                  wb_stb_i;
  logic                  wb_cyc_i;
  logic                  wb_ack_o;
  logic                  wb_err_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_timer.sv
// Wishbone responder timer: prescaled 16-bit up-counter with compare match and level interrupt.
module wb_timer #(
  parameter int          ADDR_WIDTH  = 24,
  parameter logic [15:0] RESET_PRESC = 16'h0000
) (
  input  logic      clk,
  input  logic      rst,
  wb_timer_if.slave bus,
  output logic      int_timer
);
  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PRESC  = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_CMP    = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  function automatic logic [15:0] f_merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                          input logic [1:0] sel);
    f_merge = {sel[1] ? new_v[15:8] : old_v[15:8], sel[0] ? new_v[7:0] : old_v[7:0]};
  endfunction

  logic [2:0]            r_ctrl;
  logic [15:0]           r_presc;
  logic [15:0]           r_pre_cnt;
  logic [15:0]           r_count;
  logic [15:0]           r_cmp;
  logic                  r_match;
  logic                  r_ack;
  logic                  r_err;
  logic [15:0]           r_dat;
  logic [ADDR_WIDTH-1:0] w_adr;
  logic                  w_unused;
  logic [2:0]            w_off;
  logic                  w_req;
  logic                  w_mapped;
  logic                  w_wr;
  logic                  w_wr_ctrl;
  logic                  w_wr_presc;
  logic                  w_wr_count;
  logic                  w_wr_cmp;
  logic                  w_wr_status;
  logic                  w_clr;
  logic                  w_tick;
  logic                  w_hit;
  logic [15:0]           w_rdata;

  assign w_adr    = bus.wb_adr_i;
  assign w_unused = ^w_adr;
  assign w_off    = w_adr[3:1];

  // Bus request decode, per-register write strobes and read-data mux.
  always_comb begin
    w_req       = bus.wb_cyc_i & bus.wb_stb_i & ~r_ack & ~r_err;
    w_mapped    = (w_off <= OFF_STATUS);
    w_wr        = w_req & bus.wb_we_i & w_mapped & (|bus.wb_sel_i);
    w_wr_ctrl   = 1'b0;
    w_wr_presc  = 1'b0;
    w_wr_count  = 1'b0;
    w_wr_cmp    = 1'b0;
    w_wr_status = 1'b0;
    w_rdata     = 16'h0000;
    case (w_off)
      OFF_CTRL:   begin w_wr_ctrl   = w_wr; w_rdata = {13'd0, r_ctrl};  end
      OFF_PRESC:  begin w_wr_presc  = w_wr; w_rdata = r_presc;          end
      OFF_COUNT:  begin w_wr_count  = w_wr; w_rdata = r_count;          end
      OFF_CMP:    begin w_wr_cmp    = w_wr; w_rdata = r_cmp;            end
      OFF_STATUS: begin w_wr_status = w_wr; w_rdata = {15'd0, r_match}; end
      default:    w_rdata = 16'h0000;
    endcase
  end

  // Tick generation and compare; a PRESC write restarts the prescaler without ticking.
  always_comb begin
    w_clr  = w_wr_status & bus.wb_sel_i[0] & bus.wb_dat_i[0];
    w_tick = r_ctrl[0] & (r_pre_cnt == r_presc) & ~w_wr_presc;
    w_hit  = (r_count == r_cmp);
  end

  // Single-cycle ack/err response with registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= 16'h0000;
    end else begin
      r_ack <= w_req & w_mapped;
      r_err <= w_req & ~w_mapped;
      r_dat <= (w_req & w_mapped & ~bus.wb_we_i) ? w_rdata : 16'h0000;
    end
  end

  // Timer registers; CPU writes to COUNT take priority over a same-cycle tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl    <= 3'd0;
      r_presc   <= RESET_PRESC;
      r_pre_cnt <= 16'h0000;
      r_count   <= 16'h0000;
      r_cmp     <= 16'hFFFF;
      r_match   <= 1'b0;
    end else begin
      if (w_wr_ctrl && bus.wb_sel_i[0]) r_ctrl <= bus.wb_dat_i[2:0];
      if (w_wr_presc) r_presc <= f_merge(r_presc, bus.wb_dat_i, bus.wb_sel_i);
      if (w_wr_cmp)   r_cmp   <= f_merge(r_cmp, bus.wb_dat_i, bus.wb_sel_i);

      if (w_wr_presc || !r_ctrl[0] || (r_pre_cnt == r_presc)) r_pre_cnt <= 16'h0000;
      else                                                     r_pre_cnt <= r_pre_cnt + 16'd1;

      if (w_wr_count)           r_count <= f_merge(r_count, bus.wb_dat_i, bus.wb_sel_i);
      else if (w_tick) begin
        if (w_hit && r_ctrl[2]) r_count <= 16'h0000;
        else                    r_count <= r_count + 16'd1;
      end

      r_match <= (w_tick & w_hit) | (r_match & ~w_clr);
    end
  end

  assign bus.wb_ack_o = r_ack;
  assign bus.wb_err_o = r_err;
  assign bus.wb_dat_o = r_dat;
  assign int_timer    = r_match & r_ctrl[1];
endmodule
